// File: rtl/instr_fetch_pkg.sv
// Shared CPU definitions for the fetch stage: FSM encodings, reset PC and
// instruction field positions.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_ERROR = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int OP_MSB       = 31;
    localparam int OP_LSB       = 26;
    localparam int FUNC_MSB     = 5;
    localparam int FUNC_LSB     = 0;
    localparam int IMM16_MSB    = 15;
    localparam int IMM16_LSB    = 0;
    localparam int TARGET26_MSB = 25;
    localparam int TARGET26_LSB = 0;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_next_pc.sv
// Next fetch address: jump beats a taken branch, which beats pc + 4.
// All arithmetic wraps modulo 2^32 and the result is always word aligned.
module next_pc
    import instr_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        Branch,
    input  logic        Zero,
    input  logic        Jump,
    output logic [31:0] npc
);

    logic [31:0] pc4;
    logic [31:0] imm_ext;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic        unused_opcode;

    assign unused_opcode = ^instr[OP_MSB:OP_LSB];

    always_comb begin
        pc4       = pc + 32'd4;
        imm_ext   = {{16{instr[IMM16_MSB]}}, instr[IMM16_MSB:IMM16_LSB]};
        br_target = pc4 + (imm_ext << 2);
        j_target  = {pc4[31:28], instr[TARGET26_MSB:TARGET26_LSB], 2'b00};
        npc       = word_align(pc4);
        if (Jump) begin
            npc = word_align(j_target);
        end else if (Branch && Zero) begin
            npc = word_align(br_target);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: requests one word, holds it for execute (with
// stall), then steps the PC. A memory that never answers parks the FSM in ERROR.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
    parameter logic [7:0]  IMEM_TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        Branch,
    input  logic        Zero,
    input  logic        Jump,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  func,
    output logic [31:0] pc,
    output logic        instr_valid,
    output logic        fetch_err,
    output logic [1:0]  state_dbg
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  fetch_addr_q;
    logic [31:0]  instr_q;
    logic [31:0]  npc_d;
    logic [7:0]   wait_q;
    logic [7:0]   wait_d;
    logic         req_q;
    logic         valid_q;
    logic         err_q;

    next_pc u_next_pc (
        .pc     (pc_q),
        .instr  (instr_q),
        .Branch (Branch),
        .Zero   (Zero),
        .Jump   (Jump),
        .npc    (npc_d)
    );

    assign wait_d = wait_q + 8'd1;

    // Handshake: a read completes on any cycle where imem_req and imem_ack are
    // both high; the address is held and imem_req stays up until that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_FETCH;
            pc_q         <= word_align(RESET_PC);
            fetch_addr_q <= word_align(RESET_PC);
            instr_q      <= 32'h0;
            wait_q       <= 8'd0;
            req_q        <= 1'b0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (!req_q) begin
                        // first cycle out of reset: raise the request
                        req_q <= 1'b1;
                    end else if (imem_ack) begin
                        instr_q <= imem_rdata;
                        pc_q    <= fetch_addr_q;
                        wait_q  <= 8'd0;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= ST_EXEC;
                    end else if (wait_d >= IMEM_TIMEOUT) begin
                        req_q   <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= ST_ERROR;
                    end else begin
                        wait_q <= wait_d;
                    end
                end
                ST_EXEC: begin
                    if (!stall) begin
                        fetch_addr_q <= npc_d;
                        valid_q      <= 1'b0;
                        req_q        <= 1'b1;
                        state_q      <= ST_FETCH;
                    end
                end
                ST_ERROR: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    err_q   <= 1'b1;
                end
                default: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    err_q   <= 1'b1;
                    state_q <= ST_ERROR;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = fetch_addr_q;
    assign instr       = instr_q;
    assign op          = instr_q[OP_MSB:OP_LSB];
    assign func        = instr_q[FUNC_MSB:FUNC_LSB];
    assign pc          = pc_q;
    assign instr_valid = valid_q;
    assign fetch_err   = err_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: the bench plays instruction memory and the execute
// stage, and predicts every fetch address from the instruction-set rules.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        br;
    logic        zero;
    logic        jump;
    logic        sel;

    logic        req_a, req_b, valid_a, valid_b, err_a, err_b;
    logic [31:0] addr_a, addr_b, instr_a, instr_b, pc_a, pc_b;
    logic [5:0]  op_a, op_b, func_a, func_b;
    logic [1:0]  st_a, st_b;

    logic        o_req, o_valid, o_err;
    logic [31:0] o_addr, o_instr, o_pc;
    logic [5:0]  o_op, o_func;
    logic [1:0]  o_st;

    int n_total = 0;
    int n_bad   = 0;

    instr_fetch u_dut_lo (
        .clk(clk), .rst_n(rst_n), .imem_req(req_a), .imem_addr(addr_a),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
        .Branch(br), .Zero(zero), .Jump(jump), .instr(instr_a), .op(op_a),
        .func(func_a), .pc(pc_a), .instr_valid(valid_a), .fetch_err(err_a),
        .state_dbg(st_a)
    );

    instr_fetch #(.RESET_PC(32'h4000_0000)) u_dut_hi (
        .clk(clk), .rst_n(rst_n), .imem_req(req_b), .imem_addr(addr_b),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
        .Branch(br), .Zero(zero), .Jump(jump), .instr(instr_b), .op(op_b),
        .func(func_b), .pc(pc_b), .instr_valid(valid_b), .fetch_err(err_b),
        .state_dbg(st_b)
    );

    always_comb begin
        o_req   = sel ? req_b   : req_a;
        o_addr  = sel ? addr_b  : addr_a;
        o_instr = sel ? instr_b : instr_a;
        o_op    = sel ? op_b    : op_a;
        o_func  = sel ? func_b  : func_a;
        o_pc    = sel ? pc_b    : pc_a;
        o_valid = sel ? valid_b : valid_a;
        o_err   = sel ? err_b   : err_a;
        o_st    = sel ? st_b    : st_a;
    end

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // reference model: where the next fetch goes after executing word at pc
    function automatic logic [31:0] model_next(input logic [31:0] cur_pc, input logic [31:0] word,
                                               input bit b, input bit z, input bit j);
        logic [31:0] seq;
        logic [31:0] off;
        logic [31:0] tgt;
        seq = cur_pc + 32'd4;
        off = {{16{word[15]}}, word[15:0]};
        if (j) begin
            tgt = (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) * 4);
        end else if (b && z) begin
            tgt = seq + off * 4;
        end else begin
            tgt = seq;
        end
        return tgt & 32'hFFFF_FFFC;
    endfunction

    task automatic do_reset(input logic [31:0] rpc);
        rst_n    = 1'b0;
        imem_ack = 1'b0;
        stall    = 1'b0;
        br       = 1'b0;
        zero     = 1'b0;
        jump     = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req", o_req, 0);
        check("rst_valid", o_valid, 0);
        check("rst_err", o_err, 0);
        check("rst_pc", o_pc, rpc);
        check("rst_addr", o_addr, rpc);
        check("rst_instr", o_instr, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("req_after_rst", o_req, 1);
    endtask

    // driver: serve one fetch, hold it in execute, verify the next request
    task automatic run_instr(input logic [31:0] word, input int lat, input int nstall,
                             input bit b, input bit z, input bit j, input bit junk_ack,
                             input logic [31:0] cur_addr, output logic [31:0] nxt);
        int cnt;
        cnt = 0;
        nxt = cur_addr;
        while (!o_req && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        if (!o_req) begin
            check("req_wait_timeout", 0, 1);
            return;
        end
        check("fetch_addr", o_addr, cur_addr);
        for (int k = 0; k < lat; k++) begin
            imem_ack = 1'b0;
            @(negedge clk);
            check("addr_stable", o_addr, cur_addr);
            check("req_held", o_req, 1);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        check("exec_valid", o_valid, 1);
        check("exec_instr", o_instr, word);
        check("exec_pc", o_pc, cur_addr);
        check("exec_op", {26'b0, o_op}, {26'b0, word[31:26]});
        check("exec_func", {26'b0, o_func}, {26'b0, word[5:0]});
        check("exec_req", o_req, 0);
        br    = b;
        zero  = z;
        jump  = j;
        stall = (nstall > 0);
        for (int i = 0; i < nstall; i++) begin
            imem_ack = junk_ack;
            @(negedge clk);
            imem_ack = 1'b0;
            check("stall_instr", o_instr, word);
            check("stall_pc", o_pc, cur_addr);
            check("stall_valid", o_valid, 1);
            check("stall_req", o_req, 0);
            stall = (i < nstall - 1);
        end
        nxt = model_next(cur_addr, word, b, z, j);
        @(negedge clk);
        check("next_req", o_req, 1);
        check("next_valid", o_valid, 0);
        check("next_addr", o_addr, nxt);
        check("addr_align", {30'b0, o_addr[1:0]}, 32'h0);
    endtask

    logic [31:0] a;
    logic [31:0] w;

    initial begin
        sel        = 1'b0;
        imem_rdata = 32'h0;
        do_reset(32'h0);

        // zero-wait fetch straight out of reset
        run_instr(32'h2008_0005, 0, 0, 0, 0, 0, 0, 32'h0, a);
        check("seq_after_first", o_addr, 32'h4);

        // walk to 0x10, then taken/not-taken branch
        run_instr(32'h0000_0020, 0, 0, 0, 0, 0, 0, a, a);
        run_instr(32'h0000_0020, 0, 0, 0, 0, 0, 0, a, a);
        run_instr(32'h0000_0020, 0, 0, 0, 0, 0, 0, a, a);
        run_instr(32'h1000_FFFE, 0, 0, 1, 1, 0, 0, a, a);
        check("br_taken", o_addr, 32'h0000_000C);
        run_instr(32'h0000_0020, 0, 0, 0, 0, 0, 0, a, a);
        run_instr(32'h1000_FFFE, 0, 0, 1, 0, 0, 0, a, a);
        check("br_not_taken", o_addr, 32'h0000_0014);

        // three stall cycles with stray acks, then delayed memory
        run_instr(32'h0000_0020, 0, 3, 0, 0, 0, 1, a, a);
        run_instr(32'h0000_0020, 3, 0, 0, 0, 0, 0, a, a);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 2))
                0:       w = {6'h02, 26'($urandom)};
                1:       w = {6'h04, 10'($urandom), 16'($urandom)};
                default: w = $urandom;
            endcase
            run_instr(w, $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), a, a);
        end

        // branch back past zero, then sequential wrap
        do_reset(32'h0);
        run_instr(32'h1000_FFFE, 0, 0, 1, 1, 0, 0, 32'h0, a);
        check("to_top", o_addr, 32'hFFFF_FFFC);
        run_instr(32'h0000_0020, 1, 0, 0, 0, 0, 0, a, a);
        check("wrap_zero", o_addr, 32'h0);

        // reset while a request is pending drops it at once
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        rst_n      = 1'b0;
        #1;
        check("async_req_drop", o_req, 0);
        @(negedge clk);
        check("inflight_discard", o_instr, 32'h0);
        imem_ack = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        check("refetch_req", o_req, 1);
        check("refetch_addr", o_addr, 32'h0);

        // jump wins over a taken branch (high reset PC instance)
        sel = 1'b1;
        do_reset(32'h4000_0000);
        run_instr(32'h0800_0040, 0, 0, 1, 1, 1, 0, 32'h4000_0000, a);
        check("jump_wins", o_addr, 32'h4000_0100);
        sel = 1'b0;

        // memory never answers
        do_reset(32'h0);
        for (int k = 1; k < 255; k++) begin
            @(negedge clk);
            if (k == 254) begin
                check("pre_timeout_err", o_err, 0);
                check("pre_timeout_req", o_req, 1);
            end
        end
        @(negedge clk);
        check("timeout_err", o_err, 1);
        check("timeout_req", o_req, 0);
        check("timeout_valid", o_valid, 0);
        check("timeout_state", {30'b0, o_st}, 32'd2);
        imem_ack = 1'b1;
        repeat (5) @(negedge clk);
        imem_ack = 1'b0;
        check("err_sticky", o_err, 1);
        check("err_no_req", o_req, 0);
        check("err_no_valid", o_valid, 0);
        do_reset(32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have parameter IMEM_TIMEOUT, default 8'd255, giving the maximum cycles to wait for imem_ack before flagging fetch_err.
REQ-003 The block SHALL have the following ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction-memory read request.
- imem_addr  out  32  word-aligned read address.
- imem_ack  in  1  read data valid this cycle.
- imem_rdata  in  32  instruction word.
- stall  in  1  downstream hold; freezes the current instruction.
- Branch  in  1  branch decoded for the held instruction.
- Zero  in  1  ALU equality result for the held instruction.
- Jump  in  1  jump decoded for the held instruction.
- instr  out  32  instruction register.
- op  out  6  instr[31:26], to the control decoder.
- func  out  6  instr[5:0], to the control decoder.
- pc  out  32  address of the held instruction.
- instr_valid  out  1  instr/op/func/pc are valid this cycle.
- fetch_err  out  1  sticky fetch-timeout flag.

Function
REQ-004 The FSM SHALL have the states FETCH, EXEC and ERROR, encoded in 2 bits.
REQ-005 In FETCH: imem_req=1 and imem_addr=pc_next_fetch; both SHALL stay stable until imem_ack.
REQ-006 On imem_ack in FETCH: latch imem_rdata into instr, latch the fetch address into pc, go to EXEC next cycle. An ack in the same cycle as the first req cycle SHALL be accepted (zero-wait memory gives a 2-cycle instruction period).
REQ-007 imem_ack outside FETCH SHALL be ignored.
REQ-008 In EXEC: instr_valid=1 and imem_req=0.
REQ-009 In EXEC with stall=1: instr and pc SHALL be held, and the FSM stays in EXEC.
REQ-010 In EXEC with stall=0: compute the next fetch address, go to FETCH, drop instr_valid.
REQ-011 Next-address selection, in priority order:
- Jump=1: {pc4[31:28], instr[25:0], 2'b00}.
- Branch=1 and Zero=1: pc4 + (sign-extended instr[15:0] << 2).
- otherwise: pc4, where pc4 = pc + 4.
REQ-012 All address arithmetic SHALL be 32-bit modulo 2^32; PC 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
REQ-013 imem_addr[1:0] SHALL always be 2'b00; computed targets SHALL have bits [1:0] forced to zero.
REQ-014 The wait counter SHALL count cycles in FETCH without ack; when it reaches IMEM_TIMEOUT, go to ERROR.
REQ-015 ERROR SHALL be terminal until reset: fetch_err=1, imem_req=0, instr_valid=0.
REQ-016 op and func SHALL be combinational slices of instr.

Reset
REQ-017 While rst_n=0 (asynchronous), the outputs SHALL be: state=FETCH, pc=RESET_PC, pc_next_fetch=RESET_PC, instr=32'h0, instr_valid=0, imem_req=0, fetch_err=0, wait counter=0.
REQ-018 imem_req SHALL assert on the first clk edge after rst_n rises.
REQ-019 A reset during a pending request SHALL drop imem_req immediately, and the in-flight ack SHALL be discarded.

Structure
REQ-020 The shared CPU package SHALL hold the FSM state encodings, RESET_PC default and instruction field bit positions (OP, FUNC, IMM16, TARGET26).
REQ-021 Next-address logic SHALL be a combinational sub-module next_pc (inputs pc, instr, Branch, Zero, Jump; output npc).

Verification
REQ-022 Reset, zero-wait ack, rdata 32'h2008_0005 -> instr_valid in cycle 2, op=6'h08, pc=32'h0; next imem_addr=32'h4.
REQ-023 At pc=32'h10, instr 32'h1000_FFFE, Branch=1, Zero=1 -> next imem_addr=32'h0C; with Zero=0 -> 32'h14.
REQ-024 At pc=32'h4000_0000, instr 32'h0800_0040, Jump=1, Branch=1, Zero=1 -> next imem_addr=32'h4000_0100 (Jump wins).
REQ-025 stall=1 for 3 EXEC cycles -> instr/pc/instr_valid constant, imem_req=0; advance on the cycle after stall falls.
REQ-026 imem_ack delayed 3 cycles -> imem_addr stable throughout; no ack for 255 cycles -> fetch_err=1, imem_req=0 until rst_n pulse.
REQ-027 pc=32'hFFFF_FFFC, sequential instruction -> next imem_addr=32'h0; rst_n low mid-FETCH -> imem_req drops the same cycle.
